// File: rtl/irq_request_latch.sv
// Interrupt request latch: captures request edges or levels into a pending vector
// and offers one masked line at a time, highest index first, held until acknowledged.
module irq_request_latch #(
   parameter int unsigned EDGE_MODE = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [7:0] req,
   input  logic [7:0] mask,
   input  logic       ack,
   output logic [7:0] d,
   output logic       valid,
   output logic [2:0] q,
   output logic       drop
);

   typedef enum logic {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } state_e;

   state_e     state_q, state_d;
   logic [7:0] pending_q, pending_d;
   logic [7:0] prev_req_q;
   logic [7:0] d_q, d_d;
   logic       valid_q, valid_d;
   logic [2:0] q_q, q_d;
   logic       drop_q, drop_d;

   logic [7:0] hit;
   logic [7:0] offer_vec;
   logic [2:0] top_idx;

   // NOTE: every variable gets a default before any branch so no latch is inferred,
   // and combinational logic uses blocking assignments only.
   always_comb begin
      hit       = (EDGE_MODE != 0) ? (req & ~prev_req_q) : req;
      offer_vec = pending_q & mask;

      top_idx = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (offer_vec[i]) top_idx = 3'(i);
      end

      // Ack clears first so a simultaneous capture on the same line wins.
      pending_d = pending_q;
      if (state_q == OFFER && ack) pending_d[q_q] = 1'b0;
      if (en) pending_d = pending_d | hit;

      drop_d = (EDGE_MODE != 0) && en && (|(hit & pending_q));
      d_d    = offer_vec;

      state_d = state_q;
      valid_d = valid_q;
      q_d     = q_q;
      case (state_q)
         IDLE: begin
            if (en && (|offer_vec)) begin
               q_d     = top_idx;
               valid_d = 1'b1;
               state_d = OFFER;
            end else begin
               valid_d = 1'b0;
            end
         end
         OFFER: begin
            if (ack) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            valid_d = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // NOTE: sequential state is updated with non-blocking assignments only.
   always_ff @(posedge clk) begin
      prev_req_q <= req;
      if (rst) begin
         state_q   <= IDLE;
         pending_q <= 8'h00;
         d_q       <= 8'h00;
         valid_q   <= 1'b0;
         q_q       <= 3'b000;
         drop_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         d_q       <= d_d;
         valid_q   <= valid_d;
         q_q       <= q_d;
         drop_q    <= drop_d;
      end
   end

   assign d     = d_q;
   assign valid = valid_q;
   assign q     = q_q;
   assign drop  = drop_q;

endmodule

// File: tb/tb_irq_request_latch.sv
// Self-checking bench for irq_request_latch: directed scenarios on an edge-mode and a
// level-mode instance, then randomized traffic against a cycle-level reference model.
module tb_irq_request_latch;

   logic       clk = 1'b0;
   logic       rst, en, ack;
   logic [7:0] req, mask;

   logic [7:0] d_e, d_l;
   logic       valid_e, valid_l, drop_e, drop_l;
   logic [2:0] q_e, q_l;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   irq_request_latch #(.EDGE_MODE(1)) dut_e (
      .clk(clk), .rst(rst), .en(en), .req(req), .mask(mask), .ack(ack),
      .d(d_e), .valid(valid_e), .q(q_e), .drop(drop_e)
   );

   irq_request_latch #(.EDGE_MODE(0)) dut_l (
      .clk(clk), .rst(rst), .en(en), .req(req), .mask(mask), .ack(ack),
      .d(d_l), .valid(valid_l), .q(q_l), .drop(drop_l)
   );

   // Reference model, index 0 = edge mode, index 1 = level mode.
   bit [7:0] m_pend  [2];
   bit [7:0] m_prev  [2];
   bit [7:0] m_d     [2];
   bit       m_valid [2];
   bit       m_drop  [2];
   int       m_idx   [2];

   task automatic model_edge();
      for (int k = 0; k < 2; k++) begin
         bit [7:0] new_pend;
         bit       dropped;
         if (rst) begin
            m_pend[k]  = 8'h00;
            m_d[k]     = 8'h00;
            m_valid[k] = 1'b0;
            m_drop[k]  = 1'b0;
            m_idx[k]   = 0;
         end else begin
            new_pend = m_pend[k];
            dropped  = 1'b0;
            if (m_valid[k] && ack) new_pend[m_idx[k]] = 1'b0;
            for (int i = 0; i < 8; i++) begin
               bit arrived;
               arrived = (k == 0) ? (req[i] && !m_prev[k][i]) : req[i];
               if (en && arrived) begin
                  if (m_pend[k][i] && k == 0) dropped = 1'b1;
                  new_pend[i] = 1'b1;
               end
            end
            m_d[k]    = m_pend[k] & mask;
            m_drop[k] = dropped;
            if (m_valid[k]) begin
               if (ack) m_valid[k] = 1'b0;
            end else if (en) begin
               for (int i = 7; i >= 0; i--) begin
                  if (m_pend[k][i] && mask[i]) begin
                     m_idx[k]   = i;
                     m_valid[k] = 1'b1;
                     break;
                  end
               end
            end
            m_pend[k] = new_pend;
         end
         m_prev[k] = req;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; req = 8'h00; ack = 1'b0; en = 1'b1; mask = 8'hFF;
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 8'hFF; en = 1'b1; mask = 8'hFF; ack = 1'b0;
      tick(); tick();
      total++; if (valid_e !== 1'b0) begin bad++; $display("FAIL rst_valid_e got=%b exp=0", valid_e); end
      total++; if (q_e !== 3'b000) begin bad++; $display("FAIL rst_q_e got=%0d exp=0", q_e); end
      total++; if (d_e !== 8'h00) begin bad++; $display("FAIL rst_d_e got=%h exp=00", d_e); end
      total++; if (drop_e !== 1'b0) begin bad++; $display("FAIL rst_drop_e got=%b exp=0", drop_e); end
      total++; if (valid_l !== 1'b0 || d_l !== 8'h00) begin bad++; $display("FAIL rst_level got valid=%b d=%h exp valid=0 d=00", valid_l, d_l); end
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick();
         total++; if (valid_e !== 1'b0 || d_e !== 8'h00) begin bad++; $display("FAIL rst_held_req c=%0d got valid=%b d=%h exp valid=0 d=00", c, valid_e, d_e); end
      end
   endtask

   task automatic test_single();
      do_reset();
      req = 8'h04; tick();
      total++; if (valid_e !== 1'b0) begin bad++; $display("FAIL single_early got=%b exp=0", valid_e); end
      tick();
      total++; if (valid_e !== 1'b1 || q_e !== 3'd2) begin bad++; $display("FAIL single_offer got valid=%b q=%0d exp valid=1 q=2", valid_e, q_e); end
      total++; if (d_e !== 8'h04) begin bad++; $display("FAIL single_d got=%h exp=04", d_e); end
      req = 8'h00; tick();
      total++; if (valid_e !== 1'b1 || q_e !== 3'd2) begin bad++; $display("FAIL single_hold got valid=%b q=%0d exp valid=1 q=2", valid_e, q_e); end
      ack = 1'b1; tick();
      total++; if (valid_e !== 1'b0) begin bad++; $display("FAIL single_ack got=%b exp=0", valid_e); end
      ack = 1'b0; tick();
      total++; if (d_e !== 8'h00 || valid_e !== 1'b0) begin bad++; $display("FAIL single_clear got d=%h valid=%b exp d=00 valid=0", d_e, valid_e); end
   endtask

   task automatic test_priority();
      do_reset();
      req = 8'h01; tick(); tick();
      total++; if (valid_e !== 1'b1 || q_e !== 3'd0) begin bad++; $display("FAIL prio_first got valid=%b q=%0d exp valid=1 q=0", valid_e, q_e); end
      req = 8'h81; tick();
      total++; if (valid_e !== 1'b1 || q_e !== 3'd0) begin bad++; $display("FAIL prio_stable got valid=%b q=%0d exp valid=1 q=0", valid_e, q_e); end
      req = 8'h00; tick();
      total++; if (valid_e !== 1'b1 || q_e !== 3'd0) begin bad++; $display("FAIL prio_stable2 got valid=%b q=%0d exp valid=1 q=0", valid_e, q_e); end
      ack = 1'b1; tick();
      total++; if (valid_e !== 1'b0) begin bad++; $display("FAIL prio_gap got=%b exp=0", valid_e); end
      ack = 1'b0; tick();
      total++; if (valid_e !== 1'b1 || q_e !== 3'd7) begin bad++; $display("FAIL prio_second got valid=%b q=%0d exp valid=1 q=7", valid_e, q_e); end
      ack = 1'b1; tick();
      ack = 1'b0;
      for (int c = 0; c < 2; c++) begin
         tick();
         total++; if (valid_e !== 1'b0) begin bad++; $display("FAIL prio_no_reoffer c=%0d got=%b exp=0", c, valid_e); end
      end
   endtask

   task automatic test_mask();
      do_reset();
      mask = 8'h7F; req = 8'hC0; tick();
      req = 8'h00; tick();
      total++; if (valid_e !== 1'b1 || q_e !== 3'd6) begin bad++; $display("FAIL mask_offer got valid=%b q=%0d exp valid=1 q=6", valid_e, q_e); end
      total++; if (d_e !== 8'h40) begin bad++; $display("FAIL mask_d got=%h exp=40", d_e); end
      mask = 8'hFF; ack = 1'b1; tick();
      ack = 1'b0; tick();
      total++; if (valid_e !== 1'b1 || q_e !== 3'd7) begin bad++; $display("FAIL mask_next got valid=%b q=%0d exp valid=1 q=7", valid_e, q_e); end
      mask = 8'h00; tick();
      total++; if (valid_e !== 1'b1 || q_e !== 3'd7) begin bad++; $display("FAIL mask_stands got valid=%b q=%0d exp valid=1 q=7", valid_e, q_e); end
      mask = 8'hFF; ack = 1'b1; tick();
      ack = 1'b0; tick();
      total++; if (valid_e !== 1'b0 || d_e !== 8'h00) begin bad++; $display("FAIL mask_done got valid=%b d=%h exp valid=0 d=00", valid_e, d_e); end
   endtask

   task automatic test_drop_set_wins();
      do_reset();
      req = 8'h08; tick();
      total++; if (drop_e !== 1'b0) begin bad++; $display("FAIL drop_first got=%b exp=0", drop_e); end
      req = 8'h00; tick();
      req = 8'h08; tick();
      total++; if (drop_e !== 1'b1 || valid_e !== 1'b1 || q_e !== 3'd3) begin bad++; $display("FAIL drop_pulse got drop=%b valid=%b q=%0d exp drop=1 valid=1 q=3", drop_e, valid_e, q_e); end
      tick();
      total++; if (drop_e !== 1'b0) begin bad++; $display("FAIL drop_one_cycle got=%b exp=0", drop_e); end
      req = 8'h00; tick();
      req = 8'h08; ack = 1'b1; tick();
      total++; if (valid_e !== 1'b0 || drop_e !== 1'b1) begin bad++; $display("FAIL setwin_ack got valid=%b drop=%b exp valid=0 drop=1", valid_e, drop_e); end
      req = 8'h00; ack = 1'b0; tick();
      total++; if (valid_e !== 1'b1 || q_e !== 3'd3 || drop_e !== 1'b0) begin bad++; $display("FAIL setwin_reoffer got valid=%b q=%0d drop=%b exp valid=1 q=3 drop=0", valid_e, q_e, drop_e); end
      ack = 1'b1; tick();
      ack = 1'b0; tick();
      total++; if (d_e !== 8'h00) begin bad++; $display("FAIL setwin_clear got d=%h exp=00", d_e); end
   endtask

   task automatic test_reset_mid_offer();
      do_reset();
      req = 8'h10; tick();
      req = 8'h00; tick();
      total++; if (valid_e !== 1'b1 || q_e !== 3'd4) begin bad++; $display("FAIL midrst_offer got valid=%b q=%0d exp valid=1 q=4", valid_e, q_e); end
      rst = 1'b1; tick();
      total++; if (valid_e !== 1'b0 || d_e !== 8'h00 || q_e !== 3'd0) begin bad++; $display("FAIL midrst got valid=%b d=%h q=%0d exp valid=0 d=00 q=0", valid_e, d_e, q_e); end
      rst = 1'b0; tick(); tick();
      total++; if (valid_e !== 1'b0) begin bad++; $display("FAIL midrst_discard got=%b exp=0", valid_e); end
   endtask

   task automatic test_level_mode();
      do_reset();
      req = 8'h20; ack = 1'b1; en = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         total++; if (valid_l !== ((k % 2) == 0)) begin bad++; $display("FAIL level_alt k=%0d got=%b exp=%0d", k, valid_l, (k % 2) == 0); end
         if ((k % 2) == 0) begin
            total++; if (q_l !== 3'd5) begin bad++; $display("FAIL level_q k=%0d got=%0d exp=5", k, q_l); end
         end
         total++; if (drop_l !== 1'b0) begin bad++; $display("FAIL level_drop k=%0d got=%b exp=0", k, drop_l); end
      end
      tick();
      en = 1'b0; ack = 1'b0; req = 8'h3F;
      for (int c = 0; c < 4; c++) begin
         tick();
         total++; if (valid_l !== 1'b0 || d_l !== 8'h20) begin bad++; $display("FAIL level_frozen c=%0d got valid=%b d=%h exp valid=0 d=20", c, valid_l, d_l); end
      end
      en = 1'b1; req = 8'h00;
   endtask

   task automatic test_random();
      bit [7:0] flips;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         flips = 8'h00;
         for (int i = 0; i < 8; i++) if ($urandom_range(0, 5) == 0) flips[i] = 1'b1;
         req  = req ^ flips;
         mask = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
         en   = ($urandom_range(0, 7) != 0);
         ack  = en && ($urandom_range(0, 2) == 0);
         rst  = ($urandom_range(0, 59) == 0);
         tick();
         total++; if (d_e !== m_d[0] || valid_e !== m_valid[0] || drop_e !== m_drop[0] || (m_valid[0] && q_e !== 3'(m_idx[0]))) begin
            bad++; $display("FAIL rand_edge c=%0d got d=%h v=%b q=%0d drop=%b exp d=%h v=%b q=%0d drop=%b", c, d_e, valid_e, q_e, drop_e, m_d[0], m_valid[0], m_idx[0], m_drop[0]);
         end
         total++; if (d_l !== m_d[1] || valid_l !== m_valid[1] || drop_l !== m_drop[1] || (m_valid[1] && q_l !== 3'(m_idx[1]))) begin
            bad++; $display("FAIL rand_level c=%0d got d=%h v=%b q=%0d drop=%b exp d=%h v=%b q=%0d drop=%b", c, d_l, valid_l, q_l, drop_l, m_d[1], m_valid[1], m_idx[1], m_drop[1]);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; req = 8'h00; mask = 8'hFF; ack = 1'b0;
      for (int k = 0; k < 2; k++) begin
         m_pend[k] = 8'h00; m_prev[k] = 8'h00; m_d[k] = 8'h00;
         m_valid[k] = 1'b0; m_drop[k] = 1'b0; m_idx[k] = 0;
      end
      test_reset();
      test_single();
      test_priority();
      test_mask();
      test_drop_set_wins();
      test_reset_mid_offer();
      test_level_mode();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
